logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the sequential Y86-64 datapath.
//  Supersedes the fixed 64-bit combinational OR:
//   - runtime-selectable op (AND/OR/XOR/ANDN)
//   - ZF/SF condition-code generation
//   - configurable pipeline depth with valid/ready backpressure and in-order delivery
//  Sits between the decode/operand stage and the writeback/CC-register logic.
// PARAMETERS
//  WIDTH   64  operand/result width in bits (>=2)
//  STAGES  2   number of pipeline register stages (>=1); latency with no stall
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      asynchronous, active-high reset
//  in_valid   input   1      operand set on in_a/in_b/in_op is valid
//  in_ready   output  1      unit can accept an operand set this cycle
//  in_a       input   WIDTH  operand A
//  in_b       input   WIDTH  operand B
//  in_op      input   2      00=AND 01=OR 10=XOR 11=ANDN (A & ~B)
//  out_valid  output  1      out_res/out_zf/out_sf hold a valid result
//  out_ready  input   1      consumer accepts the result this cycle
//  out_res    output  WIDTH  logic result
//  out_zf     output  1      1 when out_res == 0
//  out_sf     output  1      out_res[WIDTH-1]
//  busy       output  1      OR of all stage valid bits
// BEHAVIOUR
//  - Reset (async, immediate): all stage valid bits=0, all stage data/flags=0.
//    Outputs: out_valid=0, out_res=0, out_zf=0, out_sf=0, busy=0; in_ready=1 once
//    reset deasserts. Reset mid-stream discards every in-flight result; nothing
//    emerges after reset.
//  - Accept: input handshake when in_valid && in_ready on a rising edge.
//    Result and flags are computed combinationally from in_a/in_b/in_op and captured
//    into stage 0; stages 1..STAGES-1 carry res/zf/sf/valid only.
//  - Stage advance: stage k loads from k-1 when stage k is empty or stage k itself
//    advances. The last stage advances when out_ready=1 or out_valid=0.
//  - Bubble collapse: a bubble in stage k is filled even if downstream is stalled.
//  - in_ready = !valid[0] || stage-0 advance (combinational from out_ready through
//    the valid chain, no registered skid).
//  - Latency: exactly STAGES cycles from accept to out_valid when out_ready held 1.
//    Throughput: 1 result/cycle.
//  - Stall: while out_valid && !out_ready, out_res/out_zf/out_sf/out_valid hold
//    stable. The pipe fills to STAGES entries, then in_ready=0.
//  - Simultaneous accept and output handshake on a full pipe is permitted;
//    occupancy stays constant.
//  - Ordering: strictly FIFO; no result dropped or duplicated.
//  - Inputs are don't-care when in_valid=0; stage data changes only on a load.
//  - ZF/SF are computed over the full WIDTH; no carry/overflow (OF is the adder's
//    job).
// TESTING
//  1. Reset: assert rst mid-traffic with 2 entries in flight -> out_valid=0,
//     busy=0 within the same cycle; no stale output after release.
//  2. OR, a=64'hAA55AA55AA55AA55, b=64'h55AA55AA55AA55AA, out_ready=1
//     -> out_res=64'hFFFF_FFFF_FFFF_FFFF, zf=0, sf=1, exactly 2 cycles after
//     accept.
//  3. Ops on a=64'hF0F0, b=64'hFF00: AND->64'hF000, XOR->64'h0FF0,
//     ANDN->64'h00F0 (all zf=0, sf=0). XOR a=b=64'h1234 -> res=0, zf=1.
//  4. Backpressure: stream 5 ops back-to-back with out_ready=0
//     -> in_ready drops after 2 accepts, outputs held; release -> 5 results in
//     order, no gaps.
//  5. Random stall: random in_valid/out_ready for 10k cycles at WIDTH=64,
//     STAGES=1/2/4 -> scoreboard match, order preserved, no loss or duplication.
//  6. WIDTH=8, STAGES=1: OR 8'h80|8'h00 -> res=8'h80, sf=1, 1-cycle latency.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand side (in_*), result side (out_*)
// and the pipeline-occupancy status bit.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_zf;
   logic             out_sf;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_res, out_zf, out_sf, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_res, out_zf, out_sf, busy
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined AND/OR/XOR/ANDN unit with ZF/SF generation. STAGES-deep valid/ready
// pipe with bubble collapse; results leave strictly in acceptance order.
module logic_unit_pipe #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   logic_unit_pipe_if.slave bus
);
   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_ANDN = 2'b11
   } op_e;

   logic [WIDTH-1:0]  w_res;
   logic              w_zf;
   logic              w_sf;
   logic [STAGES-1:0] w_load;

   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] r_zf;
   logic [STAGES-1:0] r_sf;
   logic [WIDTH-1:0]  r_res [STAGES];

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_res = '0;
      case (op_e'(bus.in_op))
         OP_AND:  w_res = bus.in_a & bus.in_b;
         OP_OR:   w_res = bus.in_a | bus.in_b;
         OP_XOR:  w_res = bus.in_a ^ bus.in_b;
         OP_ANDN: w_res = bus.in_a & ~bus.in_b;
      endcase
      w_zf = (w_res == '0);
      w_sf = w_res[WIDTH-1];
   end

   // A stage loads when it is empty or its own content moves on; evaluating from the
   // output backwards lets a bubble anywhere pull everything upstream of it forward.
   always_comb begin
      w_load             = '0;
      w_load[STAGES-1]   = !r_valid[STAGES-1] || bus.out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_load[k] = !r_valid[k] || w_load[k+1];
      end
   end

   // NOTE: sequential state uses <= so each stage samples its neighbour's pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_zf    <= '0;
         r_sf    <= '0;
         // NOTE: the stage data is reset as well because the result port must read zero straight out of reset.
         for (int k = 0; k < STAGES; k++) begin
            r_res[k] <= '0;
         end
      end else begin
         if (w_load[0]) begin
            r_valid[0] <= bus.in_valid;
            if (bus.in_valid) begin
               r_res[0] <= w_res;
               r_zf[0]  <= w_zf;
               r_sf[0]  <= w_sf;
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_valid[k] <= r_valid[k-1];
               if (r_valid[k-1]) begin
                  r_res[k] <= r_res[k-1];
                  r_zf[k]  <= r_zf[k-1];
                  r_sf[k]  <= r_sf[k-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_load[0];
   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.out_res   = r_res[STAGES-1];
   assign bus.out_zf    = r_zf[STAGES-1];
   assign bus.out_sf    = r_sf[STAGES-1];
   assign bus.busy      = |r_valid;
endmodule
